// File: rtl/tilelink_arbiter_pkg.sv
// Shared TileLink-UL definitions: opcodes, arbiter state encoding and the
// beat-count helper used by the A-channel arbiter and its D-side tracking.
package tilelink_pkg;

    localparam int TL_SIZE_W  = 4;
    localparam int TL_BEATS_W = 16;

    localparam logic [2:0] TL_PUTFULL       = 3'd0;
    localparam logic [2:0] TL_PUTPARTIAL    = 3'd1;
    localparam logic [2:0] TL_GET           = 3'd4;
    localparam logic [2:0] TL_ACCESSACK     = 3'd0;
    localparam logic [2:0] TL_ACCESSACKDATA = 3'd1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Number of data beats for a message of 2^size bytes on a 2^beat_lg-byte bus
    function automatic logic [TL_BEATS_W-1:0] tl_beats(input logic [TL_SIZE_W-1:0] size,
                                                       input int beat_lg);
        if (int'(size) > beat_lg)
            return TL_BEATS_W'(1) << (int'(size) - beat_lg);
        else
            return TL_BEATS_W'(1);
    endfunction

endpackage

// File: rtl/tilelink_arbiter_if.sv
// TileLink-UL A/D channel bundle. Modport m drives the A channel (requester
// side), modport s answers it (responder side).
interface tilelink_if
    import tilelink_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_W      = 2
) ();

    logic                    a_valid;
    logic                    a_ready;
    logic [2:0]              a_opcode;
    logic [2:0]              a_param;
    logic [TL_SIZE_W-1:0]    a_size;
    logic [SRC_W-1:0]        a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [DATA_WIDTH-1:0]   a_mask;
    logic [8*DATA_WIDTH-1:0] a_data;

    logic                    d_valid;
    logic                    d_ready;
    logic [2:0]              d_opcode;
    logic [1:0]              d_param;
    logic [TL_SIZE_W-1:0]    d_size;
    logic [SRC_W-1:0]        d_source;
    logic                    d_denied;
    logic [8*DATA_WIDTH-1:0] d_data;

    modport m (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data,
        output d_ready
    );

    modport s (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data,
        input  d_ready
    );

endinterface

// File: rtl/tilelink_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan N positions starting at the pointer; the first set request wins
    always_comb begin
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N)
                cand = cand - N;
            cand_idx = IDX_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o = 1'b1;
                idx_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/tilelink_arbiter.sv
// N-to-1 TileLink-UL arbiter. Round-robin A-channel grant with burst lock for
// multi-beat Puts and a_source stamping; D channel routed back by d_source.
// Optional per-master outstanding limit: define TILELINK_ARB_INFLIGHT_EN.
module tilelink_arbiter
    import tilelink_pkg::*;
#(
    parameter int MASTERS      = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic  clk,
    input  logic  rst,
    tilelink_if.s up [MASTERS],
    tilelink_if.m dn
);

    localparam int IDX_W   = $clog2(MASTERS);
    localparam int SRC_W   = $clog2(MASTERS + 1);
    localparam int BEAT_LG = $clog2(DATA_WIDTH);
    localparam int DBITS   = 8 * DATA_WIDTH;

    logic [MASTERS-1:0]    a_valid_v;
    logic [MASTERS-1:0]    d_ready_v;
    logic [MASTERS-1:0]    eligible;
    logic [2:0]            a_opcode_a  [MASTERS];
    logic [2:0]            a_param_a   [MASTERS];
    logic [TL_SIZE_W-1:0]  a_size_a    [MASTERS];
    logic [ADDR_WIDTH-1:0] a_address_a [MASTERS];
    logic [DATA_WIDTH-1:0] a_mask_a    [MASTERS];
    logic [DBITS-1:0]      a_data_a    [MASTERS];

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]       hold_idx_q, hold_idx_d;
    logic                   hold_q, hold_d;
    logic [TL_BEATS_W-1:0]  beats_left_q, beats_left_d;

    logic [TL_BEATS_W-1:0]  msg_beats;
    logic [IDX_W-1:0]       pick_idx, grant_idx;
    logic                   pick_any, sel_ok, dn_a_valid, a_fire;
    logic                   d_in_range;
    logic [IDX_W-1:0]       d_idx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(MASTERS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    rr_pick #(.N(MASTERS), .IDX_W(IDX_W)) u_pick (
        .req_i (a_valid_v & eligible),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Grant: burst lock first, then a stalled request's held index, else round-robin
    always_comb begin
        grant_idx = pick_idx;
        sel_ok    = pick_any;
        if (state_q == BURST) begin
            grant_idx = lock_idx_q;
            sel_ok    = 1'b1;
        end else if (hold_q) begin
            grant_idx = hold_idx_q;
            sel_ok    = 1'b1;
        end
        dn_a_valid = rst && sel_ok && a_valid_v[grant_idx];
        if (a_opcode_a[grant_idx] == TL_PUTFULL || a_opcode_a[grant_idx] == TL_PUTPARTIAL)
            msg_beats = tl_beats(a_size_a[grant_idx], BEAT_LG);
        else
            msg_beats = TL_BEATS_W'(1);
    end

    assign a_fire       = dn_a_valid && dn.a_ready;
    assign dn.a_valid   = dn_a_valid;
    assign dn.a_opcode  = a_opcode_a[grant_idx];
    assign dn.a_param   = a_param_a[grant_idx];
    assign dn.a_size    = a_size_a[grant_idx];
    assign dn.a_source  = SRC_W'(grant_idx);
    assign dn.a_address = a_address_a[grant_idx];
    assign dn.a_mask    = a_mask_a[grant_idx];
    assign dn.a_data    = a_data_a[grant_idx];

    // D routing: out-of-range sources are sunk so a bad response never wedges the link
    assign d_in_range = dn.d_source < SRC_W'(MASTERS);
    assign d_idx      = IDX_W'(dn.d_source);
    assign dn.d_ready = d_in_range ? d_ready_v[d_idx] : 1'b1;

    for (genvar g = 0; g < MASTERS; g++) begin : g_up
        assign a_valid_v[g]   = up[g].a_valid;
        assign a_opcode_a[g]  = up[g].a_opcode;
        assign a_param_a[g]   = up[g].a_param;
        assign a_size_a[g]    = up[g].a_size;
        assign a_address_a[g] = up[g].a_address;
        assign a_mask_a[g]    = up[g].a_mask;
        assign a_data_a[g]    = up[g].a_data;
        assign d_ready_v[g]   = up[g].d_ready;

        assign up[g].a_ready  = rst && sel_ok && (grant_idx == IDX_W'(g)) && dn.a_ready;
        assign up[g].d_valid  = dn.d_valid && (dn.d_source == SRC_W'(g));
        assign up[g].d_opcode = dn.d_opcode;
        assign up[g].d_param  = dn.d_param;
        assign up[g].d_size   = dn.d_size;
        assign up[g].d_source = dn.d_source;
        assign up[g].d_denied = dn.d_denied;
        assign up[g].d_data   = dn.d_data;
    end

`ifdef TILELINK_ARB_INFLIGHT_EN
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic d_fire;
    assign d_fire = dn.d_valid && dn.d_ready && d_in_range;

    for (genvar g = 0; g < MASTERS; g++) begin : g_infl
        logic [CNT_W-1:0]      inflight_q;
        logic [TL_BEATS_W-1:0] dbeat_q;
        logic                  inc, dec, d_mine, d_last;

        assign d_mine  = d_fire && (d_idx == IDX_W'(g));
        assign d_last  = (dn.d_opcode != TL_ACCESSACKDATA) ||
                         (dbeat_q + TL_BEATS_W'(1) == tl_beats(dn.d_size, BEAT_LG));
        assign inc     = a_fire && (state_q == IDLE) && (grant_idx == IDX_W'(g));
        assign dec     = d_mine && d_last;
        assign eligible[g] = (inflight_q != CNT_W'(MAX_INFLIGHT));

        // Outstanding count and position within the current AccessAckData burst
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                inflight_q <= '0;
                dbeat_q    <= '0;
            end else begin
                if (inc && !dec)
                    inflight_q <= inflight_q + CNT_W'(1);
                else if (dec && !inc)
                    inflight_q <= inflight_q - CNT_W'(1);
                if (d_mine)
                    dbeat_q <= d_last ? '0 : dbeat_q + TL_BEATS_W'(1);
            end
        end
    end
`else
    assign eligible = '1;
`endif

    // Arbiter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            hold_idx_q   <= '0;
            hold_q       <= 1'b0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_idx_q   <= lock_idx_d;
            hold_idx_q   <= hold_idx_d;
            hold_q       <= hold_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Next state: burst entry/exit, pointer rotation and stall hold
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_idx_d   = lock_idx_q;
        beats_left_d = beats_left_q;
        hold_d       = (state_q == IDLE) && dn_a_valid && !dn.a_ready;
        hold_idx_d   = grant_idx;
        if (a_fire) begin
            if (state_q == IDLE) begin
                if (msg_beats > TL_BEATS_W'(1)) begin
                    state_d      = BURST;
                    lock_idx_d   = grant_idx;
                    beats_left_d = msg_beats - TL_BEATS_W'(1);
                end else begin
                    rr_ptr_d = wrap_inc(grant_idx);
                end
            end else begin
                beats_left_d = beats_left_q - TL_BEATS_W'(1);
                if (beats_left_q == TL_BEATS_W'(1)) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(lock_idx_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_tilelink_arbiter.sv
// Directed bench for tilelink_arbiter: two masters, 4-byte beats (BEAT_LG=2).
module tb_tilelink_arbiter;
    import tilelink_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tilelink_if #(.ADDR_WIDTH(32), .DATA_WIDTH(4), .SRC_W(2)) up_if [2] ();
    tilelink_if #(.ADDR_WIDTH(32), .DATA_WIDTH(4), .SRC_W(2)) dn_if ();

    tilelink_arbiter #(
        .MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(4), .MAX_INFLIGHT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .up  (up_if),
        .dn  (dn_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int m, input logic v, input logic [2:0] op,
                           input logic [3:0] sz, input logic [31:0] addr,
                           input logic [31:0] data);
        if (m == 0) begin
            up_if[0].a_valid = v; up_if[0].a_opcode = op; up_if[0].a_size = sz;
            up_if[0].a_address = addr; up_if[0].a_data = data;
        end else begin
            up_if[1].a_valid = v; up_if[1].a_opcode = op; up_if[1].a_size = sz;
            up_if[1].a_address = addr; up_if[1].a_data = data;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        up_if[0].a_param = 3'd0; up_if[0].a_mask = 4'hF; up_if[0].a_source = 2'd0;
        up_if[1].a_param = 3'd0; up_if[1].a_mask = 4'hF; up_if[1].a_source = 2'd0;
        up_if[0].d_ready = 1'b1; up_if[1].d_ready = 1'b1;
        drive_a(0, 1'b1, TL_GET, 4'd2, 32'h100, 32'h0);
        drive_a(1, 1'b1, TL_GET, 4'd2, 32'h200, 32'h0);
        dn_if.a_ready = 1'b1;
        dn_if.d_valid = 1'b0; dn_if.d_opcode = TL_ACCESSACK; dn_if.d_param = 2'd0;
        dn_if.d_size = 4'd2; dn_if.d_source = 2'd0; dn_if.d_denied = 1'b0;
        dn_if.d_data = 32'h0;
        #2;
        // reset holds every ready and the downstream valid low
        chk("rst_rdy0", up_if[0].a_ready, 1'b0);
        chk("rst_rdy1", up_if[1].a_ready, 1'b0);
        chk("rst_dnvld", dn_if.a_valid, 1'b0);
        tick();

        // 1: back-to-back Gets alternate 0,1,0,1
        do_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_src", dn_if.a_source, 64'(k % 2));
            chk("rr_addr", dn_if.a_address, (k % 2 == 1) ? 64'h200 : 64'h100);
            chk("rr_rdy0", up_if[0].a_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
            tick();
        end

        // 2: m1 4-beat PutFull holds the grant, including a mid-burst valid drop
        do_reset();
        drive_a(1, 1'b0, TL_GET, 4'd2, 32'h200, 32'h0);
        #1;
        chk("b_pre_src", dn_if.a_source, 0);
        tick();
        drive_a(1, 1'b1, TL_PUTFULL, 4'd4, 32'h300, 32'hA0);
        #1;
        chk("b1_src", dn_if.a_source, 1);
        chk("b1_data", dn_if.a_data, 32'hA0);
        chk("b1_rdy1", up_if[1].a_ready, 1'b1);
        tick();
        drive_a(1, 1'b1, TL_PUTFULL, 4'd4, 32'h300, 32'hA1);
        #1;
        chk("b2_src", dn_if.a_source, 1);
        chk("b2_rdy0", up_if[0].a_ready, 1'b0);
        tick();
        drive_a(1, 1'b0, TL_PUTFULL, 4'd4, 32'h300, 32'hA2);
        #1;
        chk("bgap_vld", dn_if.a_valid, 1'b0);
        chk("bgap_rdy0", up_if[0].a_ready, 1'b0);
        tick();
        drive_a(1, 1'b1, TL_PUTFULL, 4'd4, 32'h300, 32'hA2);
        #1;
        chk("b3_src", dn_if.a_source, 1);
        chk("b3_data", dn_if.a_data, 32'hA2);
        tick();
        drive_a(1, 1'b1, TL_PUTFULL, 4'd4, 32'h300, 32'hA3);
        #1;
        chk("b4_src", dn_if.a_source, 1);
        chk("b4_data", dn_if.a_data, 32'hA3);
        tick();
        drive_a(1, 1'b1, TL_GET, 4'd2, 32'h200, 32'h0);
        #1;
        chk("bpost_src", dn_if.a_source, 0);
        chk("bpost_addr", dn_if.a_address, 32'h100);
        tick();

        // 3: stall keeps the grant even when a higher-priority master arrives
        do_reset();
        drive_a(1, 1'b0, TL_GET, 4'd2, 32'h200, 32'h0);
        #1;
        chk("s_pre_src", dn_if.a_source, 0);
        tick();
        dn_if.a_ready = 1'b0;
        #1;
        chk("s1_src", dn_if.a_source, 0);
        chk("s1_rdy0", up_if[0].a_ready, 1'b0);
        tick();
        drive_a(1, 1'b1, TL_GET, 4'd2, 32'h200, 32'h0);
        #1;
        chk("s2_src", dn_if.a_source, 0);
        chk("s2_addr", dn_if.a_address, 32'h100);
        tick();
        #1;
        chk("s3_src", dn_if.a_source, 0);
        tick();
        dn_if.a_ready = 1'b1;
        #1;
        chk("s4_src", dn_if.a_source, 0);
        chk("s4_rdy0", up_if[0].a_ready, 1'b1);
        tick();
        #1;
        chk("s5_src", dn_if.a_source, 1);
        chk("s5_addr", dn_if.a_address, 32'h200);
        tick();

        // 4: D routing, backpressure and out-of-range sink
        drive_a(0, 1'b0, TL_GET, 4'd2, 32'h100, 32'h0);
        drive_a(1, 1'b0, TL_GET, 4'd2, 32'h200, 32'h0);
        dn_if.d_valid = 1'b1; dn_if.d_source = 2'd1; dn_if.d_opcode = TL_ACCESSACKDATA;
        dn_if.d_data = 32'hD1; up_if[1].d_ready = 1'b0;
        #1;
        chk("d_rdy_bp", dn_if.d_ready, 1'b0);
        chk("d_vld0", up_if[0].d_valid, 1'b0);
        chk("d_vld1", up_if[1].d_valid, 1'b1);
        chk("d_data1", up_if[1].d_data, 32'hD1);
        tick();
        up_if[1].d_ready = 1'b1;
        #1;
        chk("d_rdy_go", dn_if.d_ready, 1'b1);
        tick();
        dn_if.d_source = 2'd2; up_if[0].d_ready = 1'b0; up_if[1].d_ready = 1'b0;
        #1;
        chk("d_sink_rdy", dn_if.d_ready, 1'b1);
        chk("d_sink_v0", up_if[0].d_valid, 1'b0);
        chk("d_sink_v1", up_if[1].d_valid, 1'b0);
        tick();
        dn_if.d_source = 2'd0; up_if[0].d_ready = 1'b1;
        #1;
        chk("d0_vld0", up_if[0].d_valid, 1'b1);
        chk("d0_vld1", up_if[1].d_valid, 1'b0);
        tick();
        dn_if.d_valid = 1'b0; up_if[1].d_ready = 1'b1;

        // 5: reset after beat 2 of an m1 burst abandons the lock
        do_reset();
        drive_a(1, 1'b1, TL_PUTFULL, 4'd4, 32'h300, 32'hB0);
        #1;
        chk("r_b1_src", dn_if.a_source, 1);
        tick();
        drive_a(1, 1'b1, TL_PUTFULL, 4'd4, 32'h300, 32'hB1);
        #1;
        chk("r_b2_src", dn_if.a_source, 1);
        tick();
        rst = 1'b0;
        drive_a(0, 1'b1, TL_GET, 4'd2, 32'h100, 32'h0);
        #1;
        chk("r_rdy0", up_if[0].a_ready, 1'b0);
        chk("r_rdy1", up_if[1].a_ready, 1'b0);
        chk("r_dnvld", dn_if.a_valid, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("r_post_src", dn_if.a_source, 0);
        chk("r_post_addr", dn_if.a_address, 32'h100);
        chk("r_post_rdy1", up_if[1].a_ready, 1'b0);
        tick();

        // 6: outstanding-request limit
        do_reset();
        drive_a(1, 1'b0, TL_GET, 4'd2, 32'h200, 32'h0);
        #1;
        chk("i1_rdy0", up_if[0].a_ready, 1'b1);
        tick();
        #1;
        chk("i2_rdy0", up_if[0].a_ready, 1'b1);
        tick();
`ifdef TILELINK_ARB_INFLIGHT_EN
        drive_a(1, 1'b1, TL_GET, 4'd2, 32'h200, 32'h0);
        #1;
        chk("i3_rdy0", up_if[0].a_ready, 1'b0);
        chk("i3_src", dn_if.a_source, 1);
        tick();
        drive_a(1, 1'b0, TL_GET, 4'd2, 32'h200, 32'h0);
        dn_if.d_valid = 1'b1; dn_if.d_source = 2'd0; dn_if.d_opcode = TL_ACCESSACKDATA;
        dn_if.d_size = 4'd2; up_if[0].d_ready = 1'b1;
        #1;
        chk("i4_dnvld", dn_if.a_valid, 1'b0);
        chk("i4_dvld0", up_if[0].d_valid, 1'b1);
        tick();
        dn_if.d_valid = 1'b0;
        #1;
        chk("i5_rdy0", up_if[0].a_ready, 1'b1);
        chk("i5_src", dn_if.a_source, 0);
        tick();
`else
        #1;
        chk("i3_rdy0", up_if[0].a_ready, 1'b1);
        chk("i3_src", dn_if.a_source, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tilelink_arbiter.md
# tilelink_arbiter

N-to-1 TileLink-UL arbiter between `MASTERS` upstream masters and one downstream slave port. On the A channel it selects one master round-robin, holds the grant for every beat of a multi-beat Put, and stamps `a_source` with the winner's index. On the D channel it routes responses back by `d_source`. It sits between core-side TileLink masters (fetch, LSU, PTW) and the single memory-side TileLink link.

## Interface
- `MASTERS`, default 2: number of upstream masters; must be ≥2. Also the width basis of `a_source`/`d_source`.
- `ADDR_WIDTH`, default 32: address width in bits.
- `DATA_WIDTH`, default 32: beat width in bytes; `BEAT_LG = $clog2(DATA_WIDTH)`.
- `MAX_INFLIGHT`, default 4: per-master outstanding-request limit; used only with `TILELINK_ARB_INFLIGHT_EN`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `up[MASTERS]` tilelink_if.s: upstream ports; master `i` drives `up[i].a_*` and consumes `up[i].d_*`.
- `dn` tilelink_if.m: downstream port to the slave.

## Operation
- Beat count of an A message:
  - For PutFullData (0) or PutPartialData (1) with `a_size > BEAT_LG`: `1 << (a_size - BEAT_LG)`.
  - Otherwise 1, which covers Get (4) and all small requests.
- States: `IDLE`, `BURST`.
- `IDLE`:
  - Grant goes to the first valid master at or after `rr_ptr`, searching with modulo-`MASTERS` wrap.
  - Only the granted master sees `a_ready = dn.a_ready`; all others see `a_ready = 0`.
  - `dn.a_*` is muxed from the granted master, except `dn.a_source = grant index`.
  - On an A handshake of a 1-beat message: `rr_ptr ← grant+1` (wrapping), and the state stays `IDLE`.
  - On an A handshake of the first beat of an N>1 message:
    - latch `lock_idx`, set `beats_left ← N-1`, go to `BURST`;
    - `rr_ptr` is not updated.
- `BURST`:
  - Grant is forced to `lock_idx`, even if other masters are valid.
  - Each handshake decrements `beats_left`.
  - The handshake at `beats_left==1` returns the state to `IDLE` and sets `rr_ptr ← lock_idx+1`.
  - If the locked master drops `a_valid` mid-burst, `dn.a_valid = 0` and the lock is held.
- D channel:
  - `up[i].d_valid = dn.d_valid && dn.d_source==i`.
  - All `up[i].d_*` fields are broadcast from `dn`.
  - `dn.d_ready = up[dn.d_source].d_ready`.
  - A `d_source ≥ MASTERS` sinks the beat: `d_ready = 1`, and no upstream sees `d_valid`.
- Simultaneous A and D handshakes are independent.

## Timing
- A and D paths are purely combinational: zero added latency and no bubbles.
- Grant is combinational from the registered state plus the current `a_valid` vector.
- A request is stable while valid-without-ready, as TileLink requires, so grant cannot change while `dn.a_valid && !dn.a_ready` in `IDLE`.
  - To guarantee this, register `hold_idx` whenever `dn.a_valid && !dn.a_ready`, and reuse it next cycle.
- Reset values (async assert on `rst` low):
  - state `IDLE`, `rr_ptr=0`, `beats_left=0`, `lock_idx=0`, `hold` flag 0, inflight counters 0.
  - During reset, all upstream `a_ready` are 0 and `dn.a_valid` is 0.
- Reset mid-burst abandons the burst; after reset release, the next grant follows the `rr_ptr=0` search.

## Configuration
- `TILELINK_ARB_INFLIGHT_EN` defined:
  - Per-master counter `inflight[i]`, `$clog2(MAX_INFLIGHT+1)` bits.
  - Increment on the first-beat A handshake of master `i`.
  - Decrement on the last D beat for source `i`. Last beat: AccessAck, or AccessAckData beat count reached from `d_size`; this needs per-master D beat counters.
  - Master `i` is excluded from arbitration while `inflight[i]==MAX_INFLIGHT`.
  - A simultaneous increment and decrement leaves the counter unchanged.
- Undefined: no counters, and every master is always eligible.

## Structure
- Shared package `tilelink_pkg`:
  - opcode constants: `TL_PUTFULL=0`, `TL_PUTPARTIAL=1`, `TL_GET=4`, `TL_ACCESSACK=0`, `TL_ACCESSACKDATA=1`;
  - `arb_state_t` enum (`IDLE`, `BURST`);
  - function `tl_beats(size, beat_lg)`.
- One sub-module, `rr_pick`:
  - parameterised round-robin priority encoder;
  - inputs: request vector and pointer;
  - outputs: one-hot/index and `any` flag.

## Test plan
- Masters 0 and 1 both issue back-to-back 1-beat Gets with `dn.a_ready=1` → grants alternate 0,1,0,1; `dn.a_source` matches the grant.
- Master 1 issues a PutFull with `a_size=BEAT_LG+2` (4 beats) while master 0 is valid → 4 consecutive m1 beats, then m0 is granted.
- `dn.a_ready=0` for 3 cycles with both valid → grant and `dn.a_address` are stable across the stall; the handshake occurs when ready rises.
- D beat with `d_source=1`, `up[1].d_ready=0` → `dn.d_ready=0`, `up[0].d_valid=0`; once `up[1].d_ready` rises, the beat completes.
- `rst` asserted in the middle of a 4-beat burst (after beat 2) → state `IDLE`, all `a_ready` 0 during reset; afterwards m0 is granted first.
- With `TILELINK_ARB_INFLIGHT_EN`, `MAX_INFLIGHT=2`: m0 issues 2 Gets with D held off → third m0 request blocked and m1 served; one AccessAckData to m0 → m0 re-eligible next cycle.
